// File: rtl/display_buffer_n.sv
// N-digit seven-segment display buffer: positional/shift entry, leading-zero
// blanking, error blink, and parallel plus time-multiplexed segment outputs.
module display_buffer_n #(
  parameter int NUM_DIGITS = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int MUX_DIV    = 50_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          shift_en,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_pos,
  input  logic [3:0]                    wr_dig,
  input  logic                          wr_dp,
  input  logic                          lz_blank,
  input  logic [1:0]                    status,
  output logic [NUM_DIGITS*8-1:0]       seg,
  output logic [7:0]                    scan_seg,
  output logic [NUM_DIGITS-1:0]         scan_an
);

  localparam int PW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_DIV - 1);
  localparam logic [PW-1:0] IDX_LAST   = PW'(NUM_DIGITS - 1);
  localparam logic          OFF        = ACTIVE_LOW;

  logic [3:0]            code_q [NUM_DIGITS];
  logic [3:0]            code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q, dp_d;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic [MW-1:0] div_q, div_d;
  logic [PW-1:0] idx_q, idx_d;

  logic [NUM_DIGITS*8-1:0] seg_q, seg_d;
  logic [7:0]              scan_seg_q, scan_seg_d;
  logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

  logic [NUM_DIGITS-1:0] lzb;
  logic                  err;
  logic                  lit;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b0000001;
      4'hB:    s = 7'b1001111;
      4'hC:    s = 7'b0000101;
      4'hD:    s = 7'b0011101;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    code_d = code_q;
    dp_d   = dp_q;
    if (clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) code_d[k] = 4'hF;
      dp_d = '0;
    end else if (shift_en) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        code_d[k] = code_q[k-1];
        dp_d[k]   = dp_q[k-1];
      end
      code_d[0] = wr_dig;
      dp_d[0]   = wr_dp;
    end else if (wr_en) begin
      // out-of-range positions match no digit and are dropped
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (wr_pos == PW'(k)) begin
          code_d[k] = wr_dig;
          dp_d[k]   = wr_dp;
        end
      end
    end
  end

  always_comb begin
    logic run;
    lzb = '0;
    run = lz_blank;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lzb[k] = run && (code_q[k] == 4'h0) && !dp_q[k];
      // blank characters keep the run going; anything else visible ends it
      run = run && !dp_q[k] &&
            ((code_q[k] == 4'h0) || (code_q[k] >= 4'hE));
    end
  end

  assign err = (status == 2'b11);
  assign lit = !err || phase_q;

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (err) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_comb begin
    logic [7:0] raw;
    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      raw = {dec7(code_q[k]), dp_q[k]};
      if (lzb[k] || !lit) raw = 8'h00;
      seg_d[k*8 +: 8] = ACTIVE_LOW ? ~raw : raw;
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == MUX_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    scan_seg_d = {8{OFF}};
    scan_an_d  = {NUM_DIGITS{OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == PW'(k)) begin
        scan_seg_d   = seg_q[k*8 +: 8];
        scan_an_d[k] = !OFF;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) code_q[k] <= 4'hF;
      dp_q        <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      div_q       <= '0;
      idx_q       <= '0;
      seg_q       <= {(NUM_DIGITS*8){OFF}};
      scan_seg_q  <= {8{OFF}};
      scan_an_q   <= {NUM_DIGITS{OFF}};
    end else begin
      code_q      <= code_d;
      dp_q        <= dp_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      scan_seg_q  <= scan_seg_d;
      scan_an_q   <= scan_an_d;
    end
  end

  assign seg      = seg_q;
  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;

endmodule

// File: tb/tb_display_buffer_n.sv
// Directed bench for display_buffer_n: six active-low digits, fast blink/scan.
module tb_display_buffer_n;

  localparam int N = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          shift_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_pos = '0;
  logic [3:0]    wr_dig = '0;
  logic          wr_dp = 1'b0;
  logic          lz_blank = 1'b0;
  logic [1:0]    status = 2'b00;
  logic [N*8-1:0] seg;
  logic [7:0]    scan_seg;
  logic [N-1:0]  scan_an;

  int checks = 0;
  int failures = 0;

  localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LETTERS = 48'hFD61_F5C5_0303;

  display_buffer_n #(
    .NUM_DIGITS(N),
    .ACTIVE_LOW(1'b1),
    .BLINK_DIV(4),
    .MUX_DIV(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .shift_en(shift_en),
    .wr_en(wr_en),
    .wr_pos(wr_pos),
    .wr_dig(wr_dig),
    .wr_dp(wr_dp),
    .lz_blank(lz_blank),
    .status(status),
    .seg(seg),
    .scan_seg(scan_seg),
    .scan_an(scan_an)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] p, input logic [3:0] d,
                    input logic dp);
    wr_en = 1'b1; wr_pos = p; wr_dig = d; wr_dp = dp;
    step(1);
    wr_en = 1'b0; wr_dp = 1'b0;
  endtask

  task automatic shin(input logic [3:0] d);
    shift_en = 1'b1; wr_dig = d; wr_dp = 1'b0;
    step(1);
    shift_en = 1'b0;
  endtask

  logic [7:0] exp_byte [N];
  logic [5:0] exp_an;
  int         idx;

  initial begin
    exp_byte = '{8'h03, 8'h1F, 8'h49, 8'h0D, 8'h25, 8'h9F};

    step(2);
    chk("rst_seg", seg, ALL_OFF);
    chk("rst_an", scan_an, 6'h3F);
    chk("rst_scan_seg", scan_seg, 8'hFF);
    reset = 1'b1;

    wr(3'd3, 4'h7, 1'b0);
    chk("wr_latency", seg, ALL_OFF);
    step(1);
    chk("wr_d3_7", seg, 48'hFFFF_1FFF_FFFF);

    clear = 1'b1; step(1); clear = 1'b0;
    shin(4'h1); shin(4'h2); shin(4'h3);
    step(1);
    chk("shift_123", seg, 48'hFFFF_FF9F_250D);

    clear = 1'b1; wr_en = 1'b1; wr_pos = 3'd0; wr_dig = 4'h8;
    step(1);
    clear = 1'b0; wr_en = 1'b0;
    step(1);
    chk("clear_wins", seg, ALL_OFF);

    wr(3'd4, 4'h0, 1'b0); wr(3'd3, 4'h0, 1'b0); wr(3'd2, 4'h0, 1'b0);
    wr(3'd1, 4'h5, 1'b0); wr(3'd0, 4'h0, 1'b0);
    step(1);
    chk("lz_off", seg, 48'hFF03_0303_4903);
    lz_blank = 1'b1;
    step(1);
    chk("lz_on", seg, 48'hFFFF_FFFF_4903);
    wr(3'd3, 4'h0, 1'b1);
    step(1);
    chk("lz_dp", seg, 48'hFFFF_0203_4903);

    wr(3'd5, 4'h0, 1'b0); wr(3'd3, 4'h0, 1'b0); wr(3'd1, 4'h0, 1'b0);
    step(1);
    chk("lz_all_zero", seg, 48'hFFFF_FFFF_FF03);
    wr(3'd6, 4'h8, 1'b1); wr(3'd7, 4'h8, 1'b1);
    step(1);
    chk("oob_lz", seg, 48'hFFFF_FFFF_FF03);
    lz_blank = 1'b0;
    step(1);
    chk("oob_raw", seg, 48'h0303_0303_0303);

    lz_blank = 1'b1;
    wr(3'd5, 4'hA, 1'b0); wr(3'd4, 4'hB, 1'b0);
    wr(3'd3, 4'hC, 1'b0); wr(3'd2, 4'hD, 1'b0);
    step(1);
    chk("letters", seg, LETTERS);

    status = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk($sformatf("blink_%0d", i), seg, (i <= 4) ? LETTERS : ALL_OFF);
    end
    status = 2'b00;
    step(1);
    chk("blink_exit", seg, LETTERS);
    status = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk($sformatf("reblink_%0d", i), seg, (i <= 4) ? LETTERS : ALL_OFF);
    end
    status = 2'b00;
    lz_blank = 1'b0;

    reset = 1'b0;
    step(2);
    reset = 1'b1;
    shin(4'h1); shin(4'h2); shin(4'h3);
    shin(4'h5); shin(4'h7); shin(4'h0);
    step(1);
    chk("scan_seg_bus", seg, 48'h9F25_0D49_1F03);
    for (int k = 8; k <= 19; k++) begin
      step(1);
      idx = ((k - 1) / 2) % N;
      exp_an = ~(6'd1 << idx);
      chk($sformatf("scan_an_%0d", k), scan_an, exp_an);
      chk($sformatf("scan_seg_%0d", k), scan_seg, exp_byte[idx]);
    end

    #2 reset = 1'b0;
    #1;
    chk("async_an", scan_an, 6'h3F);
    chk("async_seg", seg, ALL_OFF);
    chk("async_scan_seg", scan_seg, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
